// File: rtl/btn_input_ctrl_pkg.sv
// Shared register map and bit positions for the button input peripheral.
package btn_input_ctrl_pkg;

    // Word-aligned register select taken from addr[3:2].
    typedef enum logic [1:0] {
        REG_LEVEL  = 2'd0,
        REG_STATUS = 2'd1,
        REG_EVENT  = 2'd2,
        REG_RSVD   = 2'd3
    } reg_sel_e;

    localparam int STAT_NONEMPTY_BIT = 0;
    localparam int STAT_FULL_BIT     = 1;
    localparam int STAT_OVF_BIT      = 2;
    localparam int STAT_OCC_LSB      = 8;
    localparam int STAT_OCC_W        = 5;

    localparam int EVT_VALID_BIT = 31;
    localparam int EVT_IDX_W     = 3;

    function automatic reg_sel_e decode_addr(input logic [3:0] addr);
        return reg_sel_e'(addr[3:2]);
    endfunction

endpackage

// File: rtl/btn_input_ctrl_if.sv
// CPU load/store port and interrupt line of the button peripheral.
interface btn_input_ctrl_if;
    logic        sel;
    logic        we;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    modport master (output sel, we, addr, wdata, input rdata, irq);
    modport slave  (input sel, we, addr, wdata, output rdata, irq);
endinterface

// File: rtl/btn_debounce.sv
// One button: two-flop synchronizer, debounce counter, debounced level and
// a single-cycle press strobe on the released->pressed transition.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_n,
    output logic level,
    output logic press
);

    logic        sync1_reg, sync2_reg;
    logic        level_reg, level_next;
    logic [15:0] cnt_reg, cnt_next;
    logic        sample;

    // Pins are active-low; internally 1 means pressed.
    assign sample = ~sync2_reg;

    always_comb begin
        cnt_next   = cnt_reg;
        level_next = level_reg;
        if (sample == level_reg) begin
            cnt_next = '0;
        end else if (cnt_reg + 16'd1 == 16'(DEBOUNCE_CYCLES)) begin
            level_next = sample;
            cnt_next   = '0;
        end else begin
            cnt_next = cnt_reg + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_reg <= 1'b1;
            sync2_reg <= 1'b1;
            level_reg <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            sync1_reg <= btn_n;
            sync2_reg <= sync1_reg;
            level_reg <= level_next;
            cnt_reg   <= cnt_next;
        end
    end

    assign level = level_reg;
    // Strobe in the cycle the level is about to become pressed, so the
    // pending flag lands together with the level change.
    assign press = level_next & ~level_reg;

endmodule

// File: rtl/btn_input_ctrl.sv
// Memory-mapped button peripheral: per-button debounce, press-event
// arbiter and event FIFO drained by CPU loads.
module btn_input_ctrl
    import btn_input_ctrl_pkg::*;
#(
    parameter int NUM_BTNS        = 2,
    parameter int DEBOUNCE_CYCLES = 1,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_BTNS-1:0] btn_n,
    btn_input_ctrl_if.slave     bus
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int OCC_W = STAT_OCC_W;

    logic [NUM_BTNS-1:0] level;
    logic [NUM_BTNS-1:0] press;

    generate
        for (genvar gi = 0; gi < NUM_BTNS; gi++) begin : g_btn
            btn_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_debounce (
                .clk   (clk),
                .rst_n (rst_n),
                .btn_n (btn_n[gi]),
                .level (level[gi]),
                .press (press[gi])
            );
        end
    endgenerate

    logic [NUM_BTNS-1:0]  pending_reg, pending_next;
    logic [NUM_BTNS-1:0]  grant_onehot;
    logic [EVT_IDX_W-1:0] grant_idx;
    logic                 grant_valid;

    logic [EVT_IDX_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0]     rd_ptr_reg, rd_ptr_next;
    logic [OCC_W-1:0]     occ_reg, occ_next;
    logic                 ovf_reg, ovf_next;
    logic [31:0]          rdata_reg, rdata_next;
    logic                 irq_reg;

    logic     rd_req, wr_req, empty, full, pop, push_ok, drop, ovf_clr;
    reg_sel_e rsel;

    // Lowest index wins: scan from the top so the last hit is the lowest.
    always_comb begin
        grant_valid  = 1'b0;
        grant_idx    = '0;
        grant_onehot = '0;
        for (int i = NUM_BTNS - 1; i >= 0; i--) begin
            if (pending_reg[i]) begin
                grant_valid  = 1'b1;
                grant_idx    = EVT_IDX_W'(i);
                grant_onehot = '0;
                grant_onehot[i] = 1'b1;
            end
        end
    end

    assign rd_req  = bus.sel & ~bus.we;
    assign wr_req  = bus.sel & bus.we;
    assign rsel    = decode_addr(bus.addr);
    assign empty   = (occ_reg == '0);
    assign full    = (occ_reg == OCC_W'(FIFO_DEPTH));
    assign pop     = rd_req && (rsel == REG_EVENT) && !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO
    // still succeeds then.
    assign push_ok = grant_valid && (!full || pop);
    assign drop    = grant_valid && full && !pop;
    assign ovf_clr = wr_req && (rsel == REG_STATUS) && bus.wdata[STAT_OVF_BIT];

    // A press arriving while its flag is being granted must not be lost.
    assign pending_next = (pending_reg & ~grant_onehot) | press;
    assign wr_ptr_next  = push_ok ? wr_ptr_reg + PTR_W'(1) : wr_ptr_reg;
    assign rd_ptr_next  = pop ? rd_ptr_reg + PTR_W'(1) : rd_ptr_reg;
    assign ovf_next     = drop ? 1'b1 : (ovf_clr ? 1'b0 : ovf_reg);

    always_comb begin
        occ_next = occ_reg;
        if (push_ok && !pop) begin
            occ_next = occ_reg + OCC_W'(1);
        end else if (pop && !push_ok) begin
            occ_next = occ_reg - OCC_W'(1);
        end
    end

    always_comb begin
        rdata_next = '0;
        if (rd_req) begin
            case (rsel)
                REG_LEVEL: rdata_next[NUM_BTNS-1:0] = level;
                REG_STATUS: begin
                    rdata_next[STAT_NONEMPTY_BIT]          = !empty;
                    rdata_next[STAT_FULL_BIT]              = full;
                    rdata_next[STAT_OVF_BIT]               = ovf_reg;
                    rdata_next[STAT_OCC_LSB +: STAT_OCC_W] = occ_reg;
                end
                REG_EVENT: begin
                    if (!empty) begin
                        rdata_next[EVT_VALID_BIT]   = 1'b1;
                        rdata_next[EVT_IDX_W-1:0]   = mem[rd_ptr_reg];
                    end
                end
                default: rdata_next = '0;
            endcase
        end
    end

    // Event storage carries no reset; only entries below occupancy are read.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= grant_idx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_reg <= '0;
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            occ_reg     <= '0;
            ovf_reg     <= 1'b0;
            rdata_reg   <= '0;
            irq_reg     <= 1'b0;
        end else begin
            pending_reg <= pending_next;
            wr_ptr_reg  <= wr_ptr_next;
            rd_ptr_reg  <= rd_ptr_next;
            occ_reg     <= occ_next;
            ovf_reg     <= ovf_next;
            rdata_reg   <= rdata_next;
            irq_reg     <= (occ_next != '0);
        end
    end

    assign bus.rdata = rdata_reg;
    assign bus.irq   = irq_reg;

    // Write data bits other than the overflow clear and the byte offset
    // bits have no function in this block.
    logic unused_bits;
    assign unused_bits = ^{bus.wdata[31:3], bus.wdata[1:0], bus.addr[1:0]};

endmodule

// File: tb/tb_btn_input_ctrl.sv
// Directed self-checking bench: default-parameter instance plus a
// DEBOUNCE_CYCLES=4 instance for the glitch filter cases.
module tb_btn_input_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] btn_a = 2'b11;
    logic [1:0] btn_b = 2'b11;
    int         total = 0;
    int         bad = 0;

    btn_input_ctrl_if bus_a ();
    btn_input_ctrl_if bus_b ();

    btn_input_ctrl #(.NUM_BTNS(2), .DEBOUNCE_CYCLES(1), .FIFO_DEPTH(4)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .btn_n (btn_a),
        .bus   (bus_a)
    );

    btn_input_ctrl #(.NUM_BTNS(2), .DEBOUNCE_CYCLES(4), .FIFO_DEPTH(4)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .btn_n (btn_b),
        .bus   (bus_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end else begin
            $display("ok   %s = %08h", tag, got);
        end
    endtask

    task automatic bus_idle();
        bus_a.sel = 1'b0; bus_a.we = 1'b0; bus_a.addr = 4'h0; bus_a.wdata = 32'h0;
        bus_b.sel = 1'b0; bus_b.we = 1'b0; bus_b.addr = 4'h0; bus_b.wdata = 32'h0;
    endtask

    task automatic rd_chk(input int d, input logic [3:0] a, input logic [31:0] exp, input string tag);
        logic [31:0] data;
        @(negedge clk);
        if (d == 0) begin
            bus_a.sel = 1'b1; bus_a.we = 1'b0; bus_a.addr = a;
        end else begin
            bus_b.sel = 1'b1; bus_b.we = 1'b0; bus_b.addr = a;
        end
        @(negedge clk);
        data = (d == 0) ? bus_a.rdata : bus_b.rdata;
        bus_idle();
        chk(tag, data, exp);
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] data);
        @(negedge clk);
        bus_a.sel = 1'b1; bus_a.we = 1'b1; bus_a.addr = a; bus_a.wdata = data;
        @(negedge clk);
        bus_idle();
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        logic seen;
        bus_idle();
        wait_cyc(3);
        rst_n = 1'b1;

        // 1: idle after reset
        chk("t1_irq_a", {31'b0, bus_a.irq}, 32'h0);
        chk("t1_irq_b", {31'b0, bus_b.irq}, 32'h0);
        rd_chk(0, 4'h0, 32'h0, "t1_level");
        rd_chk(0, 4'h4, 32'h0, "t1_status");
        rd_chk(0, 4'h8, 32'h0, "t1_event");
        rd_chk(0, 4'hC, 32'h0, "t1_rsvd");

        // 2: single one-cycle press on button 0
        @(negedge clk); btn_a[0] = 1'b0;
        @(negedge clk); btn_a[0] = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 6 && !seen; i++) begin
            @(negedge clk);
            if (bus_a.irq) seen = 1'b1;
        end
        chk("t2_irq_seen", {31'b0, seen}, 32'h1);
        rd_chk(0, 4'h4, 32'h0000_0101, "t2_status");
        rd_chk(0, 4'h8, 32'h8000_0000, "t2_event0");
        chk("t2_irq_clear", {31'b0, bus_a.irq}, 32'h0);
        rd_chk(0, 4'h8, 32'h0, "t2_event_empty");
        rd_chk(0, 4'h0, 32'h0, "t2_level");

        // 3: simultaneous press drains in ascending index order
        @(negedge clk); btn_a = 2'b00;
        @(negedge clk); btn_a = 2'b11;
        wait_cyc(8);
        rd_chk(0, 4'h4, 32'h0000_0201, "t3_status");
        rd_chk(0, 4'h8, 32'h8000_0000, "t3_event0");
        rd_chk(0, 4'h8, 32'h8000_0001, "t3_event1");
        rd_chk(0, 4'h8, 32'h0, "t3_event_empty");

        // 4: DEBOUNCE_CYCLES=4 glitch filter and a held press
        @(negedge clk); btn_b[0] = 1'b0;
        wait_cyc(3);
        btn_b[0] = 1'b1;
        wait_cyc(10);
        rd_chk(1, 4'h0, 32'h0, "t4_glitch_level");
        rd_chk(1, 4'h4, 32'h0, "t4_glitch_status");
        @(negedge clk); btn_b[0] = 1'b0;
        wait_cyc(6);
        btn_b[0] = 1'b1;
        rd_chk(1, 4'h0, 32'h1, "t4_held_level");
        wait_cyc(12);
        rd_chk(1, 4'h8, 32'h8000_0000, "t4_event0");
        rd_chk(1, 4'h8, 32'h0, "t4_event_once");
        rd_chk(1, 4'h0, 32'h0, "t4_release_level");

        // 5: five presses of button 1 overflow a 4-deep FIFO
        for (int p = 0; p < 5; p++) begin
            @(negedge clk); btn_a[1] = 1'b0;
            @(negedge clk); btn_a[1] = 1'b1;
            wait_cyc(6);
        end
        rd_chk(0, 4'h4, 32'h0000_0407, "t5_status_full");
        for (int r = 0; r < 4; r++) begin
            rd_chk(0, 4'h8, 32'h8000_0001, $sformatf("t5_event%0d", r));
        end
        rd_chk(0, 4'h8, 32'h0, "t5_event_empty");
        rd_chk(0, 4'h4, 32'h0000_0004, "t5_status_ovf");
        wr(4'h4, 32'h4);
        rd_chk(0, 4'h4, 32'h0, "t5_status_cleared");

        // 6: reset mid-operation discards queued events
        @(negedge clk); btn_a = 2'b00;
        @(negedge clk); btn_a = 2'b11;
        wait_cyc(8);
        rd_chk(0, 4'h4, 32'h0000_0201, "t6_status_queued");
        @(negedge clk); rst_n = 1'b0;
        #2;
        chk("t6_irq_in_reset", {31'b0, bus_a.irq}, 32'h0);
        @(negedge clk); rst_n = 1'b1;
        rd_chk(0, 4'h4, 32'h0, "t6_status");
        rd_chk(0, 4'h8, 32'h0, "t6_event");
        chk("t6_irq", {31'b0, bus_a.irq}, 32'h0);

        // 7: pin held low through reset yields exactly one event
        @(negedge clk); btn_a[0] = 1'b0; rst_n = 1'b0;
        wait_cyc(2);
        rst_n = 1'b1;
        wait_cyc(8);
        rd_chk(0, 4'h4, 32'h0000_0101, "t7_status");
        rd_chk(0, 4'h0, 32'h1, "t7_level");
        rd_chk(0, 4'h8, 32'h8000_0000, "t7_event0");
        rd_chk(0, 4'h8, 32'h0, "t7_event_once");
        btn_a[0] = 1'b1;
        wait_cyc(8);
        rd_chk(0, 4'h4, 32'h0, "t7_release_no_event");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
